// File: rtl/alu_op_sequencer.sv
// Front-end controller for the ALU: one "next" button steps through the operand-1,
// operand-2 and op-code loads. The ALU result is then captured into a registered LED output.
module alu_op_sequencer #(
  parameter int NB_IN   = 8,
  parameter int NB_OUT  = 8,
  parameter int NB_CODE = 6,
  parameter int NB_SYNC = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NB_IN-1:0]   switch,
  input  logic               b_next,
  input  logic               b_cancel,
  input  logic [NB_OUT-1:0]  alu_result,
  output logic [NB_IN-1:0]   dato1,
  output logic [NB_IN-1:0]   dato2,
  output logic [NB_CODE-1:0] op_code,
  output logic [NB_OUT-1:0]  salida,
  output logic               result_valid,
  output logic [2:0]         state
);

  // Handshake: there is none. Each button press yields exactly one
  // single-cycle pulse, and that pulse is consumed by whatever state
  // the FSM is in during that cycle.
  typedef enum logic [2:0] {
    S_D1   = 3'd0,
    S_D2   = 3'd1,
    S_CODE = 3'd2,
    S_EXEC = 3'd3,
    S_SHOW = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [NB_SYNC-1:0] next_sync, cancel_sync;
  logic               next_prev, cancel_prev;
  logic               next_p, cancel_p;

  // Button synchronizers. The prev flop turns a held level into a single pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      next_sync   <= '0;
      cancel_sync <= '0;
      next_prev   <= 1'b0;
      cancel_prev <= 1'b0;
    end else begin
      next_sync   <= {next_sync[NB_SYNC-2:0], b_next};
      cancel_sync <= {cancel_sync[NB_SYNC-2:0], b_cancel};
      next_prev   <= next_sync[NB_SYNC-1];
      cancel_prev <= cancel_sync[NB_SYNC-1];
    end
  end

  assign next_p   = next_sync[NB_SYNC-1] & ~next_prev;
  assign cancel_p = cancel_sync[NB_SYNC-1] & ~cancel_prev;

  logic load_d1, load_d2, load_code, capture, clr_valid;

  always_comb begin
    state_d   = state_q;
    load_d1   = 1'b0;
    load_d2   = 1'b0;
    load_code = 1'b0;
    capture   = 1'b0;
    clr_valid = 1'b0;
    if (cancel_p) begin
      // Cancel overrides everything, including a pending capture in S_EXEC.
      state_d   = S_D1;
      clr_valid = 1'b1;
    end else begin
      case (state_q)
        S_D1: if (next_p) begin
          load_d1 = 1'b1;
          state_d = S_D2;
        end
        S_D2: if (next_p) begin
          load_d2 = 1'b1;
          state_d = S_CODE;
        end
        S_CODE: if (next_p) begin
          load_code = 1'b1;
          state_d   = S_EXEC;
        end
        S_EXEC: begin
          capture = 1'b1;
          state_d = S_SHOW;
        end
        S_SHOW: if (next_p) begin
          clr_valid = 1'b1;
          state_d   = S_D1;
        end
        default: state_d = S_D1;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_D1;
      dato1        <= '0;
      dato2        <= '0;
      op_code      <= '0;
      salida       <= '0;
      result_valid <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load_d1)   dato1   <= switch;
      if (load_d2)   dato2   <= switch;
      if (load_code) op_code <= switch[NB_CODE-1:0];
      if (capture)   salida  <= alu_result;
      if (capture)        result_valid <= 1'b1;
      else if (clr_valid) result_valid <= 1'b0;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: directed scenarios, then randomized button/switch/reset
// activity, checked every cycle against a behavioural model.
module tb_alu_op_sequencer;
  localparam int NB_IN   = 8;
  localparam int NB_OUT  = 8;
  localparam int NB_CODE = 6;
  localparam int NB_SYNC = 2;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [NB_IN-1:0]   switch = '0;
  logic               b_next = 1'b0;
  logic               b_cancel = 1'b0;
  logic [NB_OUT-1:0]  alu_result;
  logic [NB_IN-1:0]   dato1, dato2;
  logic [NB_CODE-1:0] op_code;
  logic [NB_OUT-1:0]  salida;
  logic               result_valid;
  logic [2:0]         state;

  int n_checks = 0;
  int n_errors = 0;

  alu_op_sequencer #(.NB_IN(NB_IN), .NB_OUT(NB_OUT), .NB_CODE(NB_CODE), .NB_SYNC(NB_SYNC)) dut (
    .clk(clk), .reset(reset), .switch(switch), .b_next(b_next), .b_cancel(b_cancel),
    .alu_result(alu_result), .dato1(dato1), .dato2(dato2), .op_code(op_code),
    .salida(salida), .result_valid(result_valid), .state(state)
  );

  function automatic logic [NB_OUT-1:0] alu_f(input logic [NB_IN-1:0] a, input logic [NB_IN-1:0] b,
                                              input logic [NB_CODE-1:0] op);
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      6'h27:   return ~(a | b);
      6'h02:   return a >> b;
      6'h03:   return $signed(a) >>> b;
      default: return '0;
    endcase
  endfunction

  assign alu_result = alu_f(dato1, dato2, op_code);

  // Reference model: a press is seen NB_SYNC+1 edges after its first sample
  logic [NB_SYNC:0]   h_next = '0, h_cancel = '0;
  int                 m_state = 0;
  logic [NB_IN-1:0]   m_d1 = '0, m_d2 = '0;
  logic [NB_CODE-1:0] m_op = '0;
  logic [NB_OUT-1:0]  m_sal = '0;
  logic               m_rv = 1'b0;

  always @(posedge clk or posedge reset) begin
    logic np, cp;
    if (reset) begin
      h_next = '0; h_cancel = '0; m_state = 0;
      m_d1 = '0; m_d2 = '0; m_op = '0; m_sal = '0; m_rv = 1'b0;
    end else begin
      np = h_next[NB_SYNC-1] && !h_next[NB_SYNC];
      cp = h_cancel[NB_SYNC-1] && !h_cancel[NB_SYNC];
      h_next   = {h_next[NB_SYNC-1:0], b_next};
      h_cancel = {h_cancel[NB_SYNC-1:0], b_cancel};
      if (cp) begin
        m_state = 0; m_rv = 1'b0;
      end else if (m_state == 3) begin
        m_sal = alu_f(m_d1, m_d2, m_op); m_rv = 1'b1; m_state = 4;
      end else if (np) begin
        case (m_state)
          0: m_d1 = switch;
          1: m_d2 = switch;
          2: m_op = switch[NB_CODE-1:0];
          4: m_rv = 1'b0;
          default: ;
        endcase
        m_state = (m_state == 4) ? 0 : m_state + 1;
      end
    end
  end

  // scoreboard compare, once per cycle away from the active edge
  always @(negedge clk) begin
    n_checks++;
    if ({dato1, dato2, op_code, salida, result_valid, state} !==
        {m_d1, m_d2, m_op, m_sal, m_rv, 3'(m_state)}) begin
      n_errors++;
      $display("FAIL cycle_cmp t=%0t got d1=%h d2=%h op=%h sal=%h rv=%b st=%0d exp d1=%h d2=%h op=%h sal=%h rv=%b st=%0d",
               $time, dato1, dato2, op_code, salida, result_valid, state,
               m_d1, m_d2, m_op, m_sal, m_rv, m_state);
    end
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic press(input logic [NB_IN-1:0] sw);
    switch = sw;
    b_next = 1'b1;
    step(NB_SYNC + 1);
    b_next = 1'b0;
    step(3);
  endtask

  initial begin
    step(3);
    reset = 1'b0;
    step(2);
    chk("reset_state", 32'(state), 32'd0);

    // 5 + 3 with ADD
    press(8'h05);
    press(8'h03);
    switch = 8'h20;
    b_next = 1'b1;
    step(NB_SYNC + 1);
    chk("op_loaded", 32'(op_code), 32'h20);
    chk("exec_state", 32'(state), 32'd3);
    step(1);
    chk("show_state", 32'(state), 32'd4);
    chk("add_salida", 32'(salida), 32'h08);
    chk("add_valid", 32'(result_valid), 32'd1);
    b_next = 1'b0;
    step(3);

    // next from S_SHOW: back to S_D1, salida retained
    press(8'hFF);
    chk("show_exit_state", 32'(state), 32'd0);
    chk("show_exit_valid", 32'(result_valid), 32'd0);
    chk("show_exit_salida", 32'(salida), 32'h08);

    // held button gives exactly one advance, at the expected edge
    switch = 8'hAA;
    b_next = 1'b1;
    step(NB_SYNC);
    chk("hold_not_yet", 32'(dato1), 32'h05);
    step(1);
    chk("hold_load", 32'(dato1), 32'hAA);
    step(48);
    chk("hold_state", 32'(state), 32'd1);
    b_next = 1'b0;
    step(3);

    // next and cancel together in S_CODE: cancel wins
    press(8'h11);
    chk("code_state", 32'(state), 32'd2);
    switch = 8'h3F;
    b_next = 1'b1;
    b_cancel = 1'b1;
    step(NB_SYNC + 1);
    chk("both_state", 32'(state), 32'd0);
    chk("both_op", 32'(op_code), 32'h20);
    chk("both_d1", 32'(dato1), 32'hAA);
    chk("both_d2", 32'(dato2), 32'h11);
    chk("both_valid", 32'(result_valid), 32'd0);
    b_next = 1'b0;
    b_cancel = 1'b0;
    step(3);

    // async reset in the middle of S_CODE
    press(8'h12);
    press(8'h34);
    #2 reset = 1'b1;
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_regs", 32'({dato1, dato2, op_code, salida, result_valid}), 32'd0);
    step(1);
    reset = 1'b0;
    step(2);

    // randomized activity
    for (int i = 0; i < 4000; i++) begin
      switch = NB_IN'($urandom);
      if ($urandom_range(0, 3) == 0) b_next = ~b_next;
      if ($urandom_range(0, 24) == 0) b_cancel = ~b_cancel;
      if ($urandom_range(0, 499) == 0) begin
        #2 reset = 1'b1;
        step(1);
        reset = 1'b0;
      end else begin
        step(1);
      end
    end

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
